// File: rtl/rtm_wb_strided.sv
// rtm_wb_strided: write-back of PPU result vectors into one RTM write-port group.
// Each accepted beat is given a 2-D strided address and a per-slot enable.
// A 2-entry skid FIFO sits in front of a single output register.
// Valid/ready on both sides: a transfer happens in a cycle where valid and ready are both 1.
// ppus_out_rdy is registered, and rtm_wr_* hold steady while rtm_wr_vld=1 and rtm_wr_rdy=0.
module rtm_wb_strided #(
    parameter int  S         = 8,
    parameter int  R         = 32,
    parameter int  RTM_DEPTH = 16384,
    parameter int  DONE_DLY  = 5,
    localparam int AW        = $clog2(RTM_DEPTH),
    localparam int DW        = S * R * 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_pulse,
    input  logic [AW-1:0]   C_addr,
    input  logic [15:0]     row_len,
    input  logic [AW-1:0]   row_stride,
    input  logic [15:0]     n_rows,
    input  logic [S-1:0]    tail_mask,
    input  logic [DW-1:0]   ppus_outs,
    input  logic            ppus_out_vld,
    input  logic            ppus_out_last,
    output logic            ppus_out_rdy,
    output logic            rtm_wr_vld,
    input  logic            rtm_wr_rdy,
    output logic [S-1:0]    rtm_wr_en,
    output logic [S*AW-1:0] rtm_wr_addr,
    output logic [DW-1:0]   rtm_din,
    output logic            busy,
    output logic            done_pulse,
    output logic            err_len
);

    localparam int            CW        = (DONE_DLY > 1) ? $clog2(DONE_DLY) : 1;
    localparam logic [CW-1:0] DONE_LAST = CW'(DONE_DLY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // control state
    state_t        state_q, state_d;
    logic [15:0]   cfg_row_len_q, cfg_row_len_d;
    logic [AW-1:0] cfg_stride_q, cfg_stride_d;
    logic [S-1:0]  cfg_mask_q, cfg_mask_d;
    logic [31:0]   exp_beats_q, exp_beats_d;
    logic [15:0]   col_q, col_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [31:0]   beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_len_q, err_len_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // skid FIFO (entry 0 is the head) and output stage
    logic [DW-1:0] fifo_data_q [2];
    logic [DW-1:0] fifo_data_d [2];
    logic [AW-1:0] fifo_addr_q [2];
    logic [AW-1:0] fifo_addr_d [2];
    logic [S-1:0]  fifo_en_q   [2];
    logic [S-1:0]  fifo_en_d   [2];
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;
    logic          out_vld_q, out_vld_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [S-1:0]  out_en_q, out_en_d;
    logic [DW-1:0] out_data_q, out_data_d;

    // per-beat address and enable derived from the column/row counters
    logic          acc;
    logic          col_last;
    logic [AW-1:0] beat_addr;
    logic [S-1:0]  beat_en;
    logic          out_free;

    assign acc       = ppus_out_vld & rdy_q;
    assign col_last  = (col_q == (cfg_row_len_q - 16'd1));
    assign beat_addr = row_base_q + AW'(col_q);
    assign beat_en   = col_last ? cfg_mask_q : {S{1'b1}};
    // the output register can take new contents when empty or being written this cycle
    assign out_free  = !out_vld_q || rtm_wr_rdy;

    // datapath next state: refill the output stage from the FIFO head first, else bypass the beat
    always_comb begin
        logic [1:0] cnt_after_pop;
        logic       push;
        fifo_data_d = fifo_data_q;
        fifo_addr_d = fifo_addr_q;
        fifo_en_d   = fifo_en_q;
        fifo_cnt_d  = fifo_cnt_q;
        out_vld_d   = out_vld_q;
        out_addr_d  = out_addr_q;
        out_en_d    = out_en_q;
        out_data_d  = out_data_q;
        cnt_after_pop = fifo_cnt_q;
        push        = 1'b0;

        if (out_free) begin
            if (fifo_cnt_q != 2'd0) begin
                out_vld_d      = 1'b1;
                out_addr_d     = fifo_addr_q[0];
                out_en_d       = fifo_en_q[0];
                out_data_d     = fifo_data_q[0];
                fifo_data_d[0] = fifo_data_q[1];
                fifo_addr_d[0] = fifo_addr_q[1];
                fifo_en_d[0]   = fifo_en_q[1];
                cnt_after_pop  = fifo_cnt_q - 2'd1;
                push           = acc;
            end else if (acc) begin
                out_vld_d  = 1'b1;
                out_addr_d = beat_addr;
                out_en_d   = beat_en;
                out_data_d = ppus_outs;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else begin
            push = acc;
        end

        fifo_cnt_d = cnt_after_pop;
        if (push) begin
            // rdy is only 1 while the FIFO has room, so cnt_after_pop is 0 or 1 here
            if (cnt_after_pop == 2'd0) begin
                fifo_data_d[0] = ppus_outs;
                fifo_addr_d[0] = beat_addr;
                fifo_en_d[0]   = beat_en;
            end else begin
                fifo_data_d[1] = ppus_outs;
                fifo_addr_d[1] = beat_addr;
                fifo_en_d[1]   = beat_en;
            end
            fifo_cnt_d = cnt_after_pop + 2'd1;
        end
    end

    // control next state: FSM, config latch, address counters, length check
    always_comb begin
        state_d       = state_q;
        cfg_row_len_d = cfg_row_len_q;
        cfg_stride_d  = cfg_stride_q;
        cfg_mask_d    = cfg_mask_q;
        exp_beats_d   = exp_beats_q;
        col_d         = col_q;
        row_base_d    = row_base_q;
        beat_cnt_d    = beat_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        err_len_d     = err_len_q;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d       = ST_RUN;
                    cfg_row_len_d = row_len;
                    cfg_stride_d  = row_stride;
                    cfg_mask_d    = tail_mask;
                    exp_beats_d   = 32'(row_len) * 32'(n_rows);
                    col_d         = 16'd0;
                    row_base_d    = C_addr;
                    beat_cnt_d    = 32'd0;
                    err_len_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (acc) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    // striding keeps going past n_rows if extra beats arrive
                    if (col_last) begin
                        col_d      = 16'd0;
                        row_base_d = row_base_q + cfg_stride_q;
                    end else begin
                        col_d      = col_q + 16'd1;
                    end
                    if (ppus_out_last) begin
                        state_d = ST_DRAIN;
                        if ((beat_cnt_q + 32'd1) != exp_beats_q) begin
                            err_len_d = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // leave once the final write is handshaken and nothing is queued behind it
                if ((fifo_cnt_q == 2'd0) && out_free) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == DONE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rdy_d  = (state_d == ST_RUN) && (fifo_cnt_d != 2'd2);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_WAIT) && (wait_cnt_d == DONE_LAST);
    end

    // control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cfg_row_len_q <= '0;
            cfg_stride_q  <= '0;
            cfg_mask_q    <= '0;
            exp_beats_q   <= '0;
            col_q         <= '0;
            row_base_q    <= '0;
            beat_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            err_len_q     <= 1'b0;
            rdy_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_row_len_q <= cfg_row_len_d;
            cfg_stride_q  <= cfg_stride_d;
            cfg_mask_q    <= cfg_mask_d;
            exp_beats_q   <= exp_beats_d;
            col_q         <= col_d;
            row_base_q    <= row_base_d;
            beat_cnt_q    <= beat_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            err_len_q     <= err_len_d;
            rdy_q         <= rdy_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
                fifo_en_q[i]   <= '0;
            end
            fifo_cnt_q <= '0;
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_en_q   <= '0;
            out_data_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
                fifo_addr_q[i] <= fifo_addr_d[i];
                fifo_en_q[i]   <= fifo_en_d[i];
            end
            fifo_cnt_q <= fifo_cnt_d;
            out_vld_q  <= out_vld_d;
            out_addr_q <= out_addr_d;
            out_en_q   <= out_en_d;
            out_data_q <= out_data_d;
        end
    end

    assign ppus_out_rdy = rdy_q;
    assign rtm_wr_vld   = out_vld_q;
    assign rtm_wr_en    = out_en_q & {S{out_vld_q}};
    assign rtm_wr_addr  = {S{out_addr_q}};
    assign rtm_din      = out_data_q;
    assign busy         = busy_q;
    assign done_pulse   = done_q;
    assign err_len      = err_len_q;

endmodule

// File: tb/tb_rtm_wb_strided.sv
// Bench for rtm_wb_strided: table of operations with hand-computed endpoints,
// a write scoreboard fed by a small address model, and hand sequences for reset/start-in-RUN.
module tb_rtm_wb_strided;

    localparam int S         = 8;
    localparam int R         = 32;
    localparam int RTM_DEPTH = 16384;
    localparam int DONE_DLY  = 5;
    localparam int AW        = 14;
    localparam int DW        = S * R * 8;

    logic            clk;
    logic            rst;
    logic            start_pulse;
    logic [AW-1:0]   C_addr;
    logic [15:0]     row_len;
    logic [AW-1:0]   row_stride;
    logic [15:0]     n_rows;
    logic [S-1:0]    tail_mask;
    logic [DW-1:0]   ppus_outs;
    logic            ppus_out_vld;
    logic            ppus_out_last;
    logic            ppus_out_rdy;
    logic            rtm_wr_vld;
    logic            rtm_wr_rdy;
    logic [S-1:0]    rtm_wr_en;
    logic [S*AW-1:0] rtm_wr_addr;
    logic [DW-1:0]   rtm_din;
    logic            busy;
    logic            done_pulse;
    logic            err_len;

    rtm_wb_strided #(
        .S(S), .R(R), .RTM_DEPTH(RTM_DEPTH), .DONE_DLY(DONE_DLY)
    ) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .C_addr(C_addr),
        .row_len(row_len), .row_stride(row_stride), .n_rows(n_rows), .tail_mask(tail_mask),
        .ppus_outs(ppus_outs), .ppus_out_vld(ppus_out_vld), .ppus_out_last(ppus_out_last),
        .ppus_out_rdy(ppus_out_rdy), .rtm_wr_vld(rtm_wr_vld), .rtm_wr_rdy(rtm_wr_rdy),
        .rtm_wr_en(rtm_wr_en), .rtm_wr_addr(rtm_wr_addr), .rtm_din(rtm_din),
        .busy(busy), .done_pulse(done_pulse), .err_len(err_len)
    );

    // clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] c_addr;
        logic [15:0]   row_len;
        logic [AW-1:0] stride;
        logic [15:0]   n_rows;
        logic [S-1:0]  mask;
        int            n_beats;
        bit            rnd_rdy;
        int            mid_start_at;
        logic [AW-1:0] exp_first_addr;
        logic [AW-1:0] exp_last_addr;
        logic [S-1:0]  exp_last_en;
        bit            exp_err;
    } op_t;
    op_t ops[8];

    int total = 0;
    int bad   = 0;

    // scoreboard
    logic [AW-1:0] exp_addr_q[$];
    logic [S-1:0]  exp_en_q[$];
    logic [DW-1:0] exp_data_q[$];
    int            acc_cyc_q[$];
    int            acc_n = 0;
    int            wr_n  = 0;
    int            op_wr_cnt = 0;
    logic [AW-1:0] op_first_addr;
    logic [AW-1:0] op_last_addr;
    logic [S-1:0]  op_last_en;
    int            last_wr_cyc = 0;
    int            done_total = 0;
    int            full_hits = 0;
    bit            cur_rnd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_test();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out, got no event expected event (cycle %0d)", name, cyc);
        finish_test();
    endtask

    function automatic logic [DW-1:0] data_of(input int op, input int beat);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) begin
            d[k*32 +: 32] = 32'((op << 24) | (k << 16) | (beat ^ 16'h5a00));
        end
        return d;
    endfunction

    // RTM ready: constant 1 or 50% random, changed just after each rising edge
    initial begin
        rtm_wr_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rtm_wr_rdy = cur_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor, sampled on the falling edge: handshakes seen here complete at the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                int occ;
                occ = acc_n - wr_n;
                if (occ == 3) begin
                    full_hits++;
                    check("rdy_low_when_skid_full", ppus_out_rdy, 1'b0);
                end
                if (ppus_out_vld && ppus_out_rdy) begin
                    acc_n++;
                    acc_cyc_q.push_back(cyc);
                end
                if (!rtm_wr_vld) begin
                    check("en_zero_when_idle", rtm_wr_en, '0);
                end
                if (rtm_wr_vld && rtm_wr_rdy) begin
                    wr_n++;
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_write", 1'b1, 1'b0);
                    end else begin
                        logic [AW-1:0] ea;
                        logic [S-1:0]  ee;
                        logic [DW-1:0] ed;
                        int            ac;
                        ea = exp_addr_q.pop_front();
                        ee = exp_en_q.pop_front();
                        ed = exp_data_q.pop_front();
                        for (int s = 0; s < S; s++) begin
                            check("wr_addr", rtm_wr_addr[s*AW +: AW], ea);
                        end
                        check("wr_en", rtm_wr_en, ee);
                        total++;
                        if (rtm_din !== ed) begin
                            bad++;
                            $display("FAIL wr_data: got low %h expected low %h (cycle %0d)",
                                     rtm_din[63:0], ed[63:0], cyc);
                        end
                        if (acc_cyc_q.size() != 0) begin
                            ac = acc_cyc_q.pop_front();
                            if (!cur_rnd) check("wr_latency", cyc - ac, 1);
                        end
                    end
                    if (op_wr_cnt == 0) op_first_addr = rtm_wr_addr[AW-1:0];
                    op_last_addr = rtm_wr_addr[AW-1:0];
                    op_last_en   = rtm_wr_en;
                    op_wr_cnt++;
                    last_wr_cyc = cyc;
                end
                if (done_pulse) done_total++;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, ppus_out_rdy, 1'b0);
        check({tag, "_wr_vld"}, rtm_wr_vld, 1'b0);
        check({tag, "_wr_en"}, rtm_wr_en, '0);
        check({tag, "_wr_addr_zero"}, (rtm_wr_addr == '0), 1'b1);
        check({tag, "_din_zero"}, (rtm_din == '0), 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done_pulse, 1'b0);
        check({tag, "_err"}, err_len, 1'b0);
    endtask

    task automatic push_expected(input int i);
        int rl;
        rl = int'(ops[i].row_len);
        for (int b = 0; b < ops[i].n_beats; b++) begin
            int col;
            int row;
            col = b % rl;
            row = b / rl;
            exp_addr_q.push_back(AW'(int'(ops[i].c_addr) + row * int'(ops[i].stride) + col));
            exp_en_q.push_back((col == rl - 1) ? ops[i].mask : {S{1'b1}});
            exp_data_q.push_back(data_of(i, b));
        end
    endtask

    // send one beat and wait for it to be accepted; called just after a rising edge
    task automatic send_beat(input int i, input int b, input bit last);
        int w;
        ppus_out_vld  = 1'b1;
        ppus_outs     = data_of(i, b);
        ppus_out_last = last;
        w = 0;
        @(negedge clk);
        while (!ppus_out_rdy && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!ppus_out_rdy) timeout("beat_accept");
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int i);
        C_addr      = ops[i].c_addr;
        row_len     = ops[i].row_len;
        row_stride  = ops[i].stride;
        n_rows      = ops[i].n_rows;
        tail_mask   = ops[i].mask;
        start_pulse = 1'b1;
        @(posedge clk);
        #1;
        start_pulse = 1'b0;
        // scramble config inputs so only the latched copy can be in use
        C_addr     = ~ops[i].c_addr;
        row_len    = 16'd2;
        row_stride = 14'd777;
        n_rows     = 16'd9;
        tail_mask  = ~ops[i].mask;
    endtask

    task automatic run_op(input int i);
        int w;
        cur_rnd   = ops[i].rnd_rdy;
        op_wr_cnt = 0;
        push_expected(i);
        start_op(i);
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        check("err_cleared_by_start", err_len, 1'b0);
        @(posedge clk);
        #1;
        for (int b = 0; b < ops[i].n_beats; b++) begin
            if (b == ops[i].mid_start_at) begin
                C_addr      = 14'd3000;
                row_len     = 16'd2;
                tail_mask   = 8'h01;
                start_pulse = 1'b1;
            end
            send_beat(i, b, b == ops[i].n_beats - 1);
            start_pulse = 1'b0;
        end
        ppus_out_vld  = 1'b0;
        ppus_out_last = 1'b0;
        @(negedge clk);
        check("err_after_last_beat", err_len, ops[i].exp_err);
        check("rdy_low_after_last", ppus_out_rdy, 1'b0);
        w = 0;
        while (!done_pulse && w < 400) begin
            w++;
            @(negedge clk);
        end
        if (!done_pulse) timeout("done_pulse");
        check("done_delay", cyc - last_wr_cyc, DONE_DLY);
        check("busy_at_done", busy, 1'b1);
        check("err_at_done", err_len, ops[i].exp_err);
        check("write_count", op_wr_cnt, ops[i].n_beats);
        check("scoreboard_empty", exp_addr_q.size(), 0);
        check("first_addr", op_first_addr, ops[i].exp_first_addr);
        check("last_addr", op_last_addr, ops[i].exp_last_addr);
        check("last_en", op_last_en, ops[i].exp_last_en);
        @(negedge clk);
        check("done_one_cycle", done_pulse, 1'b0);
        check("busy_drop", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_before;
        //          c_addr  len  stride n_rows mask  beats rnd mid first  last  lasten err
        ops[0] = '{14'd100,   16'd8, 14'd0,   16'd1, 8'hFF, 8,  0, -1, 14'd100,   14'd107,  8'hFF, 0};
        ops[1] = '{14'd0,     16'd3, 14'd10,  16'd2, 8'h0F, 6,  0, -1, 14'd0,     14'd12,   8'h0F, 0};
        ops[2] = '{14'd16382, 16'd4, 14'd0,   16'd1, 8'hA5, 4,  0, -1, 14'd16382, 14'd1,    8'hA5, 0};
        ops[3] = '{14'd500,   16'd5, 14'd100, 16'd8, 8'h81, 40, 1, -1, 14'd500,   14'd1204, 8'h81, 0};
        ops[4] = '{14'd200,   16'd3, 14'd3,   16'd2, 8'h0F, 4,  0, -1, 14'd200,   14'd203,  8'hFF, 1};
        ops[5] = '{14'd50,    16'd2, 14'd4,   16'd2, 8'h33, 6,  0, -1, 14'd50,    14'd59,   8'h33, 1};
        ops[6] = '{14'd7,     16'd1, 14'd2,   16'd3, 8'h3C, 3,  0, -1, 14'd7,     14'd11,   8'h3C, 0};
        ops[7] = '{14'd1000,  16'd4, 14'd0,   16'd1, 8'hFF, 4,  0, 2,  14'd1000,  14'd1003, 8'hFF, 0};

        rst           = 1'b1;
        start_pulse   = 1'b0;
        C_addr        = '0;
        row_len       = '0;
        row_stride    = '0;
        n_rows        = '0;
        tail_mask     = '0;
        ppus_outs     = '0;
        ppus_out_vld  = 1'b0;
        ppus_out_last = 1'b0;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_op(i);
        end
        check("rdy_low_seen_with_full_skid", (full_hits > 0), 1'b1);

        // reset in the middle of an 8-beat op: everything clears, no done follows
        cur_rnd   = 1'b0;
        op_wr_cnt = 0;
        push_expected(0);
        start_op(0);
        @(posedge clk);
        #1;
        for (int b = 0; b < 3; b++) begin
            send_beat(0, b, 1'b0);
        end
        ppus_outs    = data_of(0, 3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midop_reset");
        ppus_out_vld = 1'b0;
        exp_addr_q.delete();
        exp_en_q.delete();
        exp_data_q.delete();
        acc_cyc_q.delete();
        acc_n = 0;
        wr_n  = 0;
        done_before = done_total;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("no_done_after_reset", done_total, done_before);
        check("idle_after_reset_busy", busy, 1'b0);

        // a clean op right after the reset
        run_op(0);

        finish_test();
    end

    // hard cycle limit so the bench always ends
    initial begin
        #200000;
        timeout("global_cycle_limit");
    end

endmodule
